regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with write-through bypass and a per-register pending-write scoreboard, intended as the register file for the pipelined RV32I core. Provides NR combinational read ports, NW write ports with fixed priority, and a hardwired-zero register 0. The scoreboard counts in-flight producers per register so the issue stage can stall on RAW hazards without external tracking.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers, power of two; AW = $clog2(NREGS).
- NR, 2: number of read ports.
- NW, 2: number of write ports.
- CNT_W, 2: width of each per-register pending counter.

- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_rs_addr  in  NR×AW  read addresses, packed, port k at [k*AW +: AW].
- o_rs_data  out  NR×XLEN  read data, packed likewise.
- o_rs_busy  out  NR  port k register has pending count ≠ 0.
- i_rd_wren  in  NW  write enables.
- i_rd_addr  in  NW×AW  write addresses.
- i_rd_data  in  NW×XLEN  write data.
- i_rd_rel  in  NW  write port j also releases one pending count on its register.
- i_rsv_valid  in  1  reserve request (issue of an instruction with a destination).
- i_rsv_addr  in  AW  register being reserved.
- o_sb_err  out  1  sticky: pending-counter overflow or underflow occurred.

## Operation
- Register 0: reads return 0, never busy; writes, reserves and releases to 0 ignored.
- Write priority: if several enabled ports target the same register, highest-index port wins; array updated on rising edge.
- Read bypass: o_rs_data[k] returns the winning i_rd_data when a write to that address is enabled in the same cycle, else stored value. Combinational.
- Scoreboard counter per register r ≠ 0, next = cnt + inc − dec, where inc = i_rsv_valid && i_rsv_addr==r, dec = number of ports j with i_rd_wren[j] && i_rd_rel[j] && i_rd_addr[j]==r.
- i_rd_rel without i_rd_wren on same port: ignored.
- Overflow (next > 2^CNT_W−1): counter saturates at max, o_sb_err set. Underflow (next < 0): counter held at 0, o_sb_err set.
- o_rs_busy[k] reflects registered count only (no same-cycle release/reserve forwarding); simultaneous reserve+release on same register with cnt=1 keeps count 1 and busy stays 1.
- o_sb_err sticky until reset.

## Timing
- Reset (async assert, any time including mid-write): all registers 0, all counters 0, o_sb_err 0; hence o_rs_data 0 (absent bypass), o_rs_busy 0. Writes/reserves in the reset-release cycle take effect at the first edge with i_reset low.
- Read latency 0 cycles (combinational from address and bypass inputs).
- Write-to-array latency 1 edge; bypass makes it visible in the same cycle.
- Scoreboard update 1 edge; o_rs_busy changes the cycle after the reserve/release.

## Structure
- Package rf_pkg: XLEN default, NREGS default, reg_addr_t (logic [AW-1:0]), ZERO_REG constant.
- Sub-module rf_sb_counter: one pending counter with inc, dec count (0..NW), saturation and error output; instantiated NREGS−1 times via generate. o_sb_err = OR of counter errors, registered sticky.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert i_reset asynchronously mid-cycle -> x5 reads 0 immediately, o_rs_busy 0, o_sb_err 0.
- Write/bypass: write 0x12345678 to x3 on port 0 while reading x3 on port 1 -> o_rs_data port 1 = 0x12345678 same cycle; next cycle still 0x12345678 with wren low.
- Priority: ports 0 and 1 both write x7 (0x1111, 0x2222) -> x7 = 0x2222; write 0xFFFF to x0 -> x0 reads 0.
- Scoreboard: reserve x9 twice -> busy after first edge, count 2; release once -> busy still 1; release again -> busy 0 next cycle. Reserve+release x9 same cycle at count 1 -> remains busy.
- Error: CNT_W=2, reserve x4 four times -> count 3, o_sb_err 1 after fourth; release x2 with count 0 -> o_sb_err 1, count 0; stays set until reset.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
// Contents: default data width and register count, the register address type,
// the hardwired-zero register index and a counter-limit helper.
package rf_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the pipeline and the register file.
//   master : issue/writeback side, drives read addresses, write ports and reserves
//   slave  : register file, returns read data, busy flags and the sticky error
// Packed fields: read port k at [k*AW +: AW] / [k*XLEN +: XLEN], write port j likewise.
interface regfile_mp_if #(
  parameter int unsigned XLEN  = rf_pkg::XLEN,
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 2
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NR*AW-1:0]   i_rs_addr;
  logic [NR*XLEN-1:0] o_rs_data;
  logic [NR-1:0]      o_rs_busy;
  logic [NW-1:0]      i_rd_wren;
  logic [NW*AW-1:0]   i_rd_addr;
  logic [NW*XLEN-1:0] i_rd_data;
  logic [NW-1:0]      i_rd_rel;
  logic               i_rsv_valid;
  logic [AW-1:0]      i_rsv_addr;
  logic               o_sb_err;

  modport master (
    output i_rs_addr, i_rd_wren, i_rd_addr, i_rd_data, i_rd_rel, i_rsv_valid, i_rsv_addr,
    input  o_rs_data, o_rs_busy, o_sb_err
  );

  modport slave (
    input  i_rs_addr, i_rd_wren, i_rd_addr, i_rd_data, i_rd_rel, i_rsv_valid, i_rsv_addr,
    output o_rs_data, o_rs_busy, o_sb_err
  );

endinterface

// File: rtl/rf_sb_counter.sv
// One pending-write counter of the register-file scoreboard.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_inc          : one reservation this cycle
//   i_dec          : number of releases this cycle (0..NW)
//   o_cnt          : registered pending count
//   o_err          : this cycle's update overflowed or underflowed (combinational)
module rf_sb_counter
  import rf_pkg::*;
#(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned DW    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic [DW-1:0]    i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  // Wide enough for cnt + inc and for any dec without wrap.
  localparam int unsigned SW = ((CNT_W > DW) ? CNT_W : DW) + 1;
  localparam logic [SW-1:0] MAX = SW'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    dec_w;

  always_comb begin
    sum   = SW'(cnt_q) + SW'(i_inc);
    dec_w = SW'(i_dec);
    o_err = 1'b0;
    cnt_d = cnt_q;
    if (dec_w > sum) begin
      // Release without a matching reservation: clamp at empty.
      cnt_d = '0;
      o_err = 1'b1;
    end else if ((sum - dec_w) > MAX) begin
      cnt_d = MAX[CNT_W-1:0];
      o_err = 1'b1;
    end else begin
      cnt_d = CNT_W'(sum - dec_w);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and a per-register
// pending-write scoreboard.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : NR combinational read ports with busy flags, NW write ports
//                    (highest index wins) with optional release, one reserve port,
//                    sticky scoreboard error
// Register 0 reads as zero, is never busy, and ignores writes, reserves and releases.
module regfile_mp #(
  parameter int unsigned XLEN  = rf_pkg::XLEN,
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned NR    = 2,
  parameter int unsigned NW    = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  regfile_mp_if.slave  bus
);

  import rf_pkg::*;

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned DW = $clog2(NW + 1);
  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [XLEN-1:0]    mem_q [NREGS];
  logic [CNT_W-1:0]   cnt [NREGS];
  logic               inc [1:NREGS-1];
  logic [DW-1:0]      dec [1:NREGS-1];
  logic [NREGS-1:1]   cnt_err;
  logic               sb_err_q;

  logic [AW-1:0]      rs_addr [NR];
  logic [AW-1:0]      rd_addr [NW];
  logic [XLEN-1:0]    rd_data [NW];
  logic [NR*XLEN-1:0] rs_data;
  logic [NR-1:0]      rs_busy;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      rs_addr[k] = bus.i_rs_addr[k*AW +: AW];
    end
    for (int j = 0; j < NW; j++) begin
      rd_addr[j] = bus.i_rd_addr[j*AW +: AW];
      rd_data[j] = bus.i_rd_data[j*XLEN +: XLEN];
    end
  end

  // Ascending port order with non-blocking updates: the highest enabled port wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.i_rd_wren[j] && (rd_addr[j] != ZERO)) begin
          mem_q[rd_addr[j]] <= rd_data[j];
        end
      end
    end
  end

  // Read with bypass; later ports override earlier ones to match write priority.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int k = 0; k < NR; k++) begin
      rs_data[k*XLEN +: XLEN] = mem_q[rs_addr[k]];
      for (int j = 0; j < NW; j++) begin
        if (bus.i_rd_wren[j] && (rd_addr[j] == rs_addr[k])) begin
          rs_data[k*XLEN +: XLEN] = rd_data[j];
        end
      end
      if (rs_addr[k] == ZERO) begin
        rs_data[k*XLEN +: XLEN] = '0;
      end
      rs_busy[k] = (cnt[rs_addr[k]] != '0);
    end
  end

  // Per-register reserve/release decode; a release only counts alongside its write.
  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      inc[r] = bus.i_rsv_valid && (bus.i_rsv_addr == AW'(r));
      dec[r] = '0;
      for (int j = 0; j < NW; j++) begin
        if (bus.i_rd_wren[j] && bus.i_rd_rel[j] && (rd_addr[j] == AW'(r))) begin
          dec[r] = dec[r] + DW'(1);
        end
      end
    end
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    rf_sb_counter #(
      .CNT_W (CNT_W),
      .DW    (DW)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (inc[r]),
      .i_dec   (dec[r]),
      .o_cnt   (cnt[r]),
      .o_err   (cnt_err[r])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sb_err_q <= 1'b0;
    end else if (|cnt_err) begin
      sb_err_q <= 1'b1;
    end
  end

  assign bus.o_rs_data = rs_data;
  assign bus.o_rs_busy = rs_busy;
  assign bus.o_sb_err  = sb_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed stimulus pushes expected values into
// a queue; a monitor pops and compares them against the DUT outputs on the falling edge.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned NW    = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned AW    = $clog2(NREGS);

  localparam int KData = 0;
  localparam int KBusy = 1;
  localparam int KErr  = 2;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NR    (NR),
    .NW    (NW)
  ) bus ();

  regfile_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NR    (NR),
    .NW    (NW),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  string       nm_q[$];
  int          kind_q[$];
  int          port_q[$];
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int kind, input int port, input logic [31:0] e);
    nm_q.push_back(nm);
    kind_q.push_back(kind);
    port_q.push_back(port);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational or registered, so they are valid mid-cycle.
  always @(negedge clk) begin
    string       nm;
    int          kind;
    int          port;
    logic [31:0] e;
    logic [31:0] act;
    while (kind_q.size() > 0) begin
      nm   = nm_q.pop_front();
      kind = kind_q.pop_front();
      port = port_q.pop_front();
      e    = exp_q.pop_front();
      case (kind)
        KData:   act = bus.o_rs_data[port*XLEN +: XLEN];
        KBusy:   act = {31'b0, bus.o_rs_busy[port]};
        default: act = {31'b0, bus.o_sb_err};
      endcase
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", nm, act, e);
      end
    end
  end

  task automatic idle();
    bus.i_rd_wren   = '0;
    bus.i_rd_rel    = '0;
    bus.i_rd_addr   = '0;
    bus.i_rd_data   = '0;
    bus.i_rsv_valid = 1'b0;
    bus.i_rsv_addr  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d, input bit rel);
    bus.i_rd_wren[p]              = 1'b1;
    bus.i_rd_rel[p]               = rel;
    bus.i_rd_addr[p*AW +: AW]     = AW'(a);
    bus.i_rd_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input int a);
    bus.i_rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rsv(input int a);
    bus.i_rsv_valid = 1'b1;
    bus.i_rsv_addr  = AW'(a);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_rs_addr = '0;
    idle();

    // Reset state
    step(); rd(0, 5); rd(1, 9);
    chk("rst_data", KData, 0, 32'h0);
    chk("rst_busy", KBusy, 1, 32'h0);
    chk("rst_err", KErr, 0, 32'h0);

    // Write x5, then async reset mid-cycle clears it immediately
    step(); rst = 1'b0; wr(0, 5, 32'hDEADBEEF, 1'b0);
    chk("byp_x5", KData, 0, 32'hDEADBEEF);
    step();
    chk("stored_x5", KData, 0, 32'hDEADBEEF);
    step(); rst = 1'b1;
    chk("async_rst_data", KData, 0, 32'h0);
    chk("async_rst_busy", KBusy, 0, 32'h0);
    chk("async_rst_err", KErr, 0, 32'h0);

    // Write/bypass across ports
    step(); rst = 1'b0; wr(0, 3, 32'h12345678, 1'b0); rd(1, 3);
    chk("byp_x3", KData, 1, 32'h12345678);
    step();
    chk("stored_x3", KData, 1, 32'h12345678);

    // Priority and register 0
    step(); wr(0, 7, 32'h1111, 1'b0); wr(1, 7, 32'h2222, 1'b0); rd(0, 7);
    chk("prio_byp_x7", KData, 0, 32'h2222);
    step(); wr(1, 0, 32'hFFFF, 1'b0); rd(1, 0);
    chk("prio_x7", KData, 0, 32'h2222);
    chk("x0_byp", KData, 1, 32'h0);
    step();
    chk("x0_stored", KData, 1, 32'h0);

    // Scoreboard on x9
    step(); rd(0, 9); rsv(9);
    chk("sb_pre", KBusy, 0, 32'h0);
    step(); rsv(9);
    chk("sb_rsv1", KBusy, 0, 32'h1);
    step(); wr(0, 9, 32'h0, 1'b1);
    chk("sb_cnt2", KBusy, 0, 32'h1);
    step(); wr(1, 9, 32'h0, 1'b1);
    chk("sb_rel1", KBusy, 0, 32'h1);
    step(); rsv(9);
    chk("sb_rel2", KBusy, 0, 32'h0);
    step(); rsv(9); wr(0, 9, 32'h0, 1'b1);
    chk("sb_cnt1", KBusy, 0, 32'h1);
    step(); wr(0, 9, 32'h0, 1'b1);
    chk("sb_rsv_rel", KBusy, 0, 32'h1);
    step();
    chk("sb_empty", KBusy, 0, 32'h0);
    chk("sb_no_err", KErr, 0, 32'h0);

    // Underflow on x2
    step(); wr(0, 2, 32'h0, 1'b1); rd(1, 2);
    chk("uf_pre", KErr, 0, 32'h0);
    step(); rsv(2);
    chk("uf_err", KErr, 0, 32'h1);
    chk("uf_cnt0", KBusy, 1, 32'h0);
    step(); wr(0, 2, 32'h0, 1'b1);
    chk("uf_rsv", KBusy, 1, 32'h1);
    step();
    chk("uf_rel", KBusy, 1, 32'h0);
    chk("uf_sticky", KErr, 0, 32'h1);
    step(); rst = 1'b1;
    chk("rst_err2", KErr, 0, 32'h0);

    // Overflow on x4: four reserves saturate at 3
    step(); rst = 1'b0; rsv(4); rd(0, 4);
    step(); rsv(4);
    chk("of_busy", KBusy, 0, 32'h1);
    step(); rsv(4);
    step(); rsv(4);
    chk("of_pre", KErr, 0, 32'h0);
    step();
    wr(0, 4, 32'h0, 1'b1);
    bus.i_rd_rel[1] = 1'b1;  // release without write enable must be ignored
    bus.i_rd_addr[AW +: AW] = AW'(4);
    chk("of_err", KErr, 0, 32'h1);
    chk("of_cnt3", KBusy, 0, 32'h1);
    step(); wr(0, 4, 32'h0, 1'b1);
    chk("of_cnt2", KBusy, 0, 32'h1);
    step(); wr(0, 4, 32'h0, 1'b1);
    chk("of_cnt1", KBusy, 0, 32'h1);
    step(); rsv(0); rd(1, 0);
    chk("of_cnt0", KBusy, 0, 32'h0);
    chk("of_sticky", KErr, 0, 32'h1);
    step();
    chk("x0_busy", KBusy, 1, 32'h0);
    step(); rst = 1'b1;
    chk("rst_err3", KErr, 0, 32'h0);
    step(); rst = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    if (kind_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", kind_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
